ecc_mem_scrub_ctrl: RTL and testbench

Controller for a small word-organised array built from `ecc_mem_bit` cells. It shares the array's single load port between an external write requester and a background scrubber. The scrubber periodically walks every word, detects words whose cells report `err`, and rewrites them with their corrected value. It also provides a registered read port and error statistics to the CPU-side status logic.

---
 rtl/ecc_mem_pkg.sv | 26 ++
 rtl/ecc_mem_bit.sv | 29 ++
 rtl/ecc_mem_word.sv | 27 ++
 rtl/ecc_mem_scrub_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ecc_mem_scrub_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_mem_pkg.sv
// Shared types and helpers for the ECC scrubbed word array: FSM states,
// error-counter sizing, the cell-copy majority vote and saturating increment.
package ecc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        if (v == ERR_CNT_MAX) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/ecc_mem_bit.sv
// One storage bit held as three copies; reads the majority and flags any
// disagreement between copies.
module ecc_mem_bit
    import ecc_mem_pkg::*;
(
    input  logic clk,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic err
);

    logic c0_r;
    logic c1_r;
    logic c2_r;

    // Copies are written together; an unloaded cell keeps its (possibly upset) state
    always_ff @(posedge clk) begin
        if (ld) begin
            c0_r <= d;
            c1_r <= d;
            c2_r <= d;
        end
    end

    assign q   = maj3(c0_r, c1_r, c2_r);
    assign err = (c0_r ^ c1_r) | (c1_r ^ c2_r);

endmodule

// File: rtl/ecc_mem_word.sv
// One array word: WIDTH triplicated cells sharing a load enable, exposing
// the corrected value and an OR-reduced error flag.
module ecc_mem_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] val,
    output logic             err
);

    logic [WIDTH-1:0] bit_err_s;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        ecc_mem_bit u_bit (
            .clk (clk),
            .ld  (ld),
            .d   (d[b]),
            .q   (val[b]),
            .err (bit_err_s[b])
        );
    end

    assign err = |bit_err_s;

endmodule

// File: rtl/ecc_mem_scrub_ctrl.sv
// Scrub controller: arbitrates the single array load port between external
// writes and a periodic scanner that rewrites words reporting cell errors.
module ecc_mem_scrub_ctrl
    import ecc_mem_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int SCAN_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_err,
    input  logic                 scan_en,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    last_err_addr
);

    localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    state_e                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [ADDR_W-1:0]      scan_addr_r, scan_addr_s;
    logic                   scan_done_s, err_pulse_s;
    logic                   wr_fire_s, wr_hit_s, last_s;
    logic [WIDTH-1:0]       val_s [DEPTH];
    logic [DEPTH-1:0]       err_s;
    logic [DEPTH-1:0]       ld_s;
    logic [WIDTH-1:0]       ld_data_s;
    logic                   wr_ready_r, scan_busy_r, scan_done_r, err_pulse_r, rd_err_r;
    logic [WIDTH-1:0]       rd_data_r;
    logic [ERR_CNT_W-1:0]   err_count_r;
    logic [ADDR_W-1:0]      last_err_addr_r;

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        ecc_mem_word #(.WIDTH(WIDTH)) u_word (
            .clk (clk),
            .ld  (ld_s[w]),
            .d   (ld_data_s),
            .val (val_s[w]),
            .err (err_s[w])
        );
    end

    assign wr_fire_s = wr_valid && wr_ready_r;
    assign wr_hit_s  = wr_fire_s && (wr_addr == scan_addr_r);
    assign last_s    = (scan_addr_r == ADDR_W'(DEPTH - 1));

    // Next-state and pulse decode; a same-cycle write to the scanned word supersedes the fix
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        scan_addr_s = scan_addr_r;
        scan_done_s = 1'b0;
        err_pulse_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!scan_en) begin
                    cnt_s = '0;
                end else if (cnt_r == CNT_W'(SCAN_PERIOD - 1)) begin
                    state_s     = ST_SCAN;
                    cnt_s       = '0;
                    scan_addr_s = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (!scan_en) begin
                    state_s     = ST_IDLE;
                    scan_addr_s = '0;
                end else if (err_s[scan_addr_r] && !wr_hit_s) begin
                    state_s = ST_FIX;
                end else if (last_s) begin
                    state_s     = ST_IDLE;
                    scan_addr_s = '0;
                    scan_done_s = 1'b1;
                end else begin
                    scan_addr_s = scan_addr_r + ADDR_W'(1);
                end
            end
            ST_FIX: begin
                err_pulse_s = 1'b1;
                if (last_s) begin
                    state_s     = ST_IDLE;
                    scan_addr_s = '0;
                    scan_done_s = 1'b1;
                end else if (!scan_en) begin
                    state_s     = ST_IDLE;
                    scan_addr_s = '0;
                end else begin
                    state_s     = ST_SCAN;
                    scan_addr_s = scan_addr_r + ADDR_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = '0;
                scan_addr_s = '0;
            end
        endcase
    end

    // Load-port arbitration: FIX owns the port, otherwise an accepted write does
    always_comb begin
        ld_s      = '0;
        ld_data_s = wr_data;
        if (state_r == ST_FIX) begin
            ld_s[scan_addr_r] = 1'b1;
            ld_data_s         = val_s[scan_addr_r];
        end else if (wr_fire_s) begin
            ld_s[wr_addr] = 1'b1;
        end else begin
            ld_s = '0;
        end
    end

    // State, counters, read register and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cnt_r           <= '0;
            scan_addr_r     <= '0;
            wr_ready_r      <= 1'b1;
            scan_busy_r     <= 1'b0;
            scan_done_r     <= 1'b0;
            err_pulse_r     <= 1'b0;
            err_count_r     <= '0;
            last_err_addr_r <= '0;
            rd_data_r       <= '0;
            rd_err_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            scan_addr_r <= scan_addr_s;
            wr_ready_r  <= (state_s != ST_FIX);
            scan_busy_r <= (state_s != ST_IDLE);
            scan_done_r <= scan_done_s;
            err_pulse_r <= err_pulse_s;
            if (err_pulse_s) begin
                err_count_r     <= sat_inc(err_count_r);
                last_err_addr_r <= scan_addr_r;
            end
            rd_data_r <= val_s[rd_addr];
            rd_err_r  <= err_s[rd_addr];
        end
    end

    assign wr_ready      = wr_ready_r;
    assign scan_busy     = scan_busy_r;
    assign scan_done     = scan_done_r;
    assign err_pulse     = err_pulse_r;
    assign err_count     = err_count_r;
    assign last_err_addr = last_err_addr_r;
    assign rd_data       = rd_data_r;
    assign rd_err        = rd_err_r;

endmodule

// File: tb/tb_ecc_mem_scrub_ctrl.sv
// Directed/randomised bench for ecc_mem_scrub_ctrl: cell upsets are planted by
// briefly forcing one copy of a cell, and a word-level model predicts each pass.
module tb_ecc_mem_scrub_ctrl;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int P      = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, wr_valid, wr_ready, rd_err, scan_en, scan_busy, scan_done, err_pulse;
    logic [ADDR_W-1:0] wr_addr, rd_addr, last_err_addr;
    logic [WIDTH-1:0]  wr_data, rd_data;
    logic [7:0]        err_count;

    ecc_mem_scrub_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SCAN_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_err(rd_err), .scan_en(scan_en), .scan_busy(scan_busy), .scan_done(scan_done),
        .err_pulse(err_pulse), .err_count(err_count), .last_err_addr(last_err_addr)
    );

    int                checks = 0;
    int                errors = 0;
    logic [WIDTH-1:0]  mem_m  [DEPTH];
    logic [WIDTH-1:0]  flip_m [DEPTH];
    int                cnt_m;
    logic [ADDR_W-1:0] last_m;
    int                r_first, r_busy, r_done, r_rdylow, r_acc;
    logic [ADDR_W-1:0] pulse_q[$];
    logic [ADDR_W-1:0] exp_q[$];
    logic [DEPTH*WIDTH-1:0] inj_tog;

    // Upset injector: each toggle of inj_tog flips copy 0 of one cell
    for (genvar gw = 0; gw < DEPTH; gw++) begin : g_inj_w
        for (genvar gb = 0; gb < WIDTH; gb++) begin : g_inj_b
            always @(inj_tog[gw*WIDTH+gb]) begin
                if (dut.g_word[gw].u_word.g_bit[gb].u_bit.c0_r)
                    force dut.g_word[gw].u_word.g_bit[gb].u_bit.c0_r = 1'b0;
                else
                    force dut.g_word[gw].u_word.g_bit[gb].u_bit.c0_r = 1'b1;
                #1;
                release dut.g_word[gw].u_word.g_bit[gb].u_bit.c0_r;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_idle(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_valid = 1'b0;
        mem_m[a] = d;
        flip_m[a] = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a);
        rd_addr = a;
        step();
        chk({tag, "_data"}, 32'(rd_data), 32'(mem_m[a]));
        chk({tag, "_err"}, 32'(rd_err), 32'(flip_m[a] != '0));
    endtask

    task automatic inject(input int w, input int b);
        inj_tog[5'(w*WIDTH+b)] = ~inj_tog[5'(w*WIDTH+b)];
        #2;
        flip_m[2'(w)][3'(b)] = ~flip_m[2'(w)][3'(b)];
    endtask

    // Words the scanner should repair, in address order; 'skip' is a word overwritten mid-pass
    task automatic expect_errs(input int skip);
        exp_q.delete();
        for (int w = 0; w < DEPTH; w++)
            if (w != skip && flip_m[w] != '0) exp_q.push_back(ADDR_W'(w));
    endtask

    task automatic run_pass(input int wr_k, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        logic acc;
        r_first = 0; r_busy = 0; r_done = 0; r_rdylow = 0; r_acc = 0;
        pulse_q.delete();
        scan_en = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            if (k == wr_k) begin
                wr_valid = 1'b1; wr_addr = wa; wr_data = wd;
            end
            acc = wr_valid && wr_ready;
            step();
            if (acc) begin
                wr_valid = 1'b0;
                r_acc = k;
            end
            if (scan_busy) begin
                r_busy++;
                if (r_first == 0) r_first = k;
            end
            if (!wr_ready) r_rdylow++;
            if (err_pulse) pulse_q.push_back(last_err_addr);
            if (scan_done) begin
                r_done = k;
                break;
            end
        end
        scan_en = 1'b0;
        wr_valid = 1'b0;
        chk("pass_timeout", 32'(r_done != 0), 32'd1);
    endtask

    task automatic check_pass(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, "_first_busy"}, 32'(r_first), 32'(P));
        chk({tag, "_busy_cycles"}, 32'(r_busy), 32'(DEPTH + n));
        chk({tag, "_done_at"}, 32'(r_done), 32'(P + DEPTH + n));
        chk({tag, "_ready_low"}, 32'(r_rdylow), 32'(n));
        chk({tag, "_pulses"}, 32'(pulse_q.size()), 32'(n));
        for (int i = 0; i < n && i < pulse_q.size(); i++)
            chk({tag, "_pulse_addr"}, 32'(pulse_q[i]), 32'(exp_q[i]));
        foreach (exp_q[i]) flip_m[exp_q[i]] = '0;
        cnt_m = (cnt_m + n > 255) ? 255 : cnt_m + n;
        if (n > 0) last_m = exp_q[n-1];
        chk({tag, "_err_count"}, 32'(err_count), 32'(cnt_m));
        chk({tag, "_last_addr"}, 32'(last_err_addr), 32'(last_m));
    endtask

    initial begin
        logic [WIDTH-1:0] nd;
        int total, nd_done, nd_pulse;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        scan_en = 1'b0; inj_tog = '0; cnt_m = 0; last_m = '0;
        for (int w = 0; w < DEPTH; w++) begin
            mem_m[w] = '0; flip_m[w] = '0;
        end
        repeat (3) step();
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_err", 32'(rd_err), 32'd0);
        chk("rst_busy", 32'(scan_busy), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        chk("rst_count", 32'(err_count), 32'd0);
        chk("rst_last", 32'(last_err_addr), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++) wr_idle(ADDR_W'(w), WIDTH'($urandom));
        wr_idle(2'd2, 8'hA5);
        rd_chk("rd_a5", 2'd2);
        for (int i = 0; i < 6; i++) begin
            wr_idle(ADDR_W'($urandom), WIDTH'($urandom));
            rd_chk("rd_rand", ADDR_W'($urandom));
        end

        // Single upset in word 1, bit 3
        wr_idle(2'd1, WIDTH'($urandom));
        inject(1, 3);
        rd_chk("upset_pre", 2'd1);
        expect_errs(-1);
        run_pass(-1, '0, '0);
        check_pass("upset");
        rd_chk("upset_post", 2'd1);

        // Write lands on word 3 in the very cycle the scanner inspects it
        inject(3, int'($urandom_range(0, 7)));
        expect_errs(3);
        nd = WIDTH'($urandom);
        run_pass(P + DEPTH, 2'd3, nd);
        check_pass("coll");
        chk("coll_accept", 32'(r_acc), 32'(P + DEPTH));
        mem_m[3] = nd; flip_m[3] = '0;
        rd_chk("coll_rd", 2'd3);

        // Write presented during the FIX of word 1 stalls one cycle
        inject(1, int'($urandom_range(0, 7)));
        expect_errs(-1);
        nd = WIDTH'($urandom);
        run_pass(P + 3, 2'd0, nd);
        check_pass("stall");
        chk("stall_accept", 32'(r_acc), 32'(P + 4));
        mem_m[0] = nd; flip_m[0] = '0;
        rd_chk("stall_rd", 2'd0);

        // Saturation over many passes with random error sets
        total = 0;
        for (int p = 0; p < 200 && total < 260; p++) begin
            int mask;
            mask = int'($urandom_range(1, 15));
            for (int w = 0; w < DEPTH; w++)
                if (mask[w]) begin
                    inject(w, int'($urandom_range(0, 7)));
                    total++;
                end
            expect_errs(-1);
            run_pass(-1, '0, '0);
            check_pass("sat");
            wr_idle(ADDR_W'($urandom), WIDTH'($urandom));
            rd_chk("sat_rd", ADDR_W'($urandom));
        end
        chk("sat_final", 32'(err_count), 32'd255);

        // scan_en dropped while scanning word 1
        inject(2, int'($urandom_range(0, 7)));
        scan_en = 1'b1;
        repeat (P + 1) step();
        chk("drop_busy_pre", 32'(scan_busy), 32'd1);
        scan_en = 1'b0;
        nd_done = 0; nd_pulse = 0;
        step();
        chk("drop_busy_post", 32'(scan_busy), 32'd0);
        nd_done += int'(scan_done); nd_pulse += int'(err_pulse);
        repeat (20) begin
            step();
            nd_done += int'(scan_done); nd_pulse += int'(err_pulse);
        end
        chk("drop_no_done", 32'(nd_done), 32'd0);
        chk("drop_no_pulse", 32'(nd_pulse), 32'd0);
        chk("drop_count", 32'(err_count), 32'(cnt_m));
        rd_chk("drop_rd", 2'd2);
        expect_errs(-1);
        run_pass(-1, '0, '0);
        check_pass("after_drop");

        // Reset while the scanner is on word 2
        inject(3, int'($urandom_range(0, 7)));
        scan_en = 1'b1;
        repeat (P + 2) step();
        chk("rst_mid_busy_pre", 32'(scan_busy), 32'd1);
        rst = 1'b1; scan_en = 1'b0;
        step();
        rst = 1'b0;
        cnt_m = 0; last_m = '0;
        chk("rst_mid_busy", 32'(scan_busy), 32'd0);
        chk("rst_mid_count", 32'(err_count), 32'd0);
        chk("rst_mid_last", 32'(last_err_addr), 32'd0);
        chk("rst_mid_ready", 32'(wr_ready), 32'd1);
        inject(0, int'($urandom_range(0, 7)));
        expect_errs(-1);
        run_pass(-1, '0, '0);
        check_pass("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
